decode_pipe: RTL and testbench

//  Parametrised LEGv8 decode stage with its ID/EX pipeline register: register file,
//  W->D write-through bypass, immediate extraction, stall/flush control.

---
 rtl/legv8_pkg.sv | 24 ++
 rtl/decode_pipe_regfile_bypass.sv | 59 +++++
 rtl/decode_pipe.sv | 113 +++++++++++
 tb/tb_decode_pipe.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// Shared LEGv8 decode definitions: opcode fields, XZR index and the ID/EX bundle.
package legv8_pkg;

    localparam logic [10:0] OP_LDUR = 11'h7C2;
    localparam logic [10:0] OP_STUR = 11'h7C0;
    localparam logic [7:0]  OP_CBZ  = 8'hB4;
    localparam logic [5:0]  OP_B    = 6'h05;

    localparam int XZR_INDEX   = 31;
    localparam int XLEN_MAX    = 64;
    localparam int REG_FIELD_W = 5;

    // Data fields are sized for the widest datapath; narrower builds use the low bits.
    typedef struct packed {
        logic                   valid;
        logic [31:0]            instr;
        logic [XLEN_MAX-1:0]    read_data1;
        logic [XLEN_MAX-1:0]    read_data2;
        logic [XLEN_MAX-1:0]    sign_imm;
        logic [REG_FIELD_W-1:0] ra1;
        logic [REG_FIELD_W-1:0] ra2;
    } idex_t;

endpackage

// File: rtl/decode_pipe_regfile_bypass.sv
// Register file with two read ports, one write port and optional W->D write-through.
module regfile_bypass
    import legv8_pkg::*;
#(
    parameter int N        = 64,
    parameter int NREG     = 32,
    parameter int ZERO_REG = XZR_INDEX,
    parameter int BYPASS   = 1,
    localparam int A       = $clog2(NREG)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [A-1:0] ra1,
    input  logic [A-1:0] ra2,
    input  logic         we,
    input  logic [A-1:0] wa,
    input  logic [N-1:0] wd,
    output logic [N-1:0] rd1,
    output logic [N-1:0] rd2
);

    logic [N-1:0] regs_q [NREG];
    logic [N-1:0] regs_d [NREG];

    // XZR and out-of-range addresses read as zero before any bypass is considered.
    function automatic logic [N-1:0] read_port(
        input logic [A-1:0] ra,
        input logic [N-1:0] stored,
        input logic         we_i,
        input logic [A-1:0] wa_i,
        input logic [N-1:0] wd_i
    );
        if (int'(ra) == ZERO_REG) return '0;
        if (int'(ra) >= NREG) return '0;
        if ((BYPASS != 0) && we_i && (wa_i == ra)) return wd_i;
        return stored;
    endfunction

    always_comb begin
        regs_d = regs_q;
        if (we && (int'(wa) != ZERO_REG) && (int'(wa) < NREG)) begin
            regs_d[wa] = wd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rd1 = read_port(ra1, (int'(ra1) < NREG) ? regs_q[ra1] : '0, we, wa, wd);
        rd2 = read_port(ra2, (int'(ra2) < NREG) ? regs_q[ra2] : '0, we, wa, wd);
    end

endmodule

// File: rtl/decode_pipe.sv
// LEGv8 decode stage: register read, immediate extraction and the ID/EX register
// with flush/stall control and write-back refresh of held operands.
module decode_pipe
    import legv8_pkg::*;
#(
    parameter int N        = 64,
    parameter int NREG     = 32,
    parameter int ZERO_REG = XZR_INDEX,
    parameter int BYPASS   = 1,
    localparam int A       = $clog2(NREG)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  instr_D,
    input  logic         valid_D,
    input  logic         reg2loc_D,
    input  logic         stall_D,
    input  logic         flush_D,
    input  logic         regWrite_W,
    input  logic [A-1:0] wa3_W,
    input  logic [N-1:0] writeData3_W,
    output logic         valid_E,
    output logic [31:0]  instr_E,
    output logic [N-1:0] readData1_E,
    output logic [N-1:0] readData2_E,
    output logic [N-1:0] signImm_E,
    output logic [A-1:0] ra1_E,
    output logic [A-1:0] ra2_E
);

    logic [A-1:0] ra1_d;
    logic [A-1:0] ra2_d;
    logic [N-1:0] rd1_d;
    logic [N-1:0] rd2_d;
    logic [N-1:0] sign_imm_d;
    idex_t        idex_d;
    idex_t        idex_q;

    always_comb begin
        ra1_d = A'(instr_D[9:5]);
        ra2_d = reg2loc_D ? A'(instr_D[4:0]) : A'(instr_D[20:16]);
    end

    regfile_bypass #(
        .N        (N),
        .NREG     (NREG),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_regfile (
        .clk   (clk),
        .reset (reset),
        .ra1   (ra1_d),
        .ra2   (ra2_d),
        .we    (regWrite_W),
        .wa    (wa3_W),
        .wd    (writeData3_W),
        .rd1   (rd1_d),
        .rd2   (rd2_d)
    );

    always_comb begin
        sign_imm_d = '0;
        if ((instr_D[31:21] == OP_LDUR) || (instr_D[31:21] == OP_STUR)) begin
            sign_imm_d = {{(N-9){instr_D[20]}}, instr_D[20:12]};
        end else if (instr_D[31:24] == OP_CBZ) begin
            sign_imm_d = {{(N-19){instr_D[23]}}, instr_D[23:5]};
        end else if (instr_D[31:26] == OP_B) begin
            sign_imm_d = {{(N-26){instr_D[25]}}, instr_D[25:0]};
        end
    end

    // While stalled, a write-back to a held source register replaces the stale operand.
    always_comb begin
        idex_d = idex_q;
        if (flush_D) begin
            idex_d = '0;
        end else if (stall_D) begin
            if (regWrite_W && (wa3_W == ra1_E) && (int'(ra1_E) != ZERO_REG)) begin
                idex_d.read_data1 = XLEN_MAX'(writeData3_W);
            end
            if (regWrite_W && (wa3_W == ra2_E) && (int'(ra2_E) != ZERO_REG)) begin
                idex_d.read_data2 = XLEN_MAX'(writeData3_W);
            end
        end else begin
            idex_d.valid      = valid_D;
            idex_d.instr      = instr_D;
            idex_d.read_data1 = XLEN_MAX'(rd1_d);
            idex_d.read_data2 = XLEN_MAX'(rd2_d);
            idex_d.sign_imm   = XLEN_MAX'(sign_imm_d);
            idex_d.ra1        = REG_FIELD_W'(ra1_d);
            idex_d.ra2        = REG_FIELD_W'(ra2_d);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    always_comb begin
        valid_E     = idex_q.valid;
        instr_E     = idex_q.instr;
        readData1_E = N'(idex_q.read_data1);
        readData2_E = N'(idex_q.read_data2);
        signImm_E   = N'(idex_q.sign_imm);
        ra1_E       = A'(idex_q.ra1);
        ra2_E       = A'(idex_q.ra2);
    end

endmodule

// File: tb/tb_decode_pipe.sv
// Randomised and directed bench for decode_pipe, driving a BYPASS=1 and a BYPASS=0
// instance with identical stimulus and comparing both against a behavioural model.
module tb_decode_pipe;

    logic        clk;
    logic        reset;
    logic [31:0] instr_D;
    logic        valid_D;
    logic        reg2loc_D;
    logic        stall_D;
    logic        flush_D;
    logic        regWrite_W;
    logic [4:0]  wa3_W;
    logic [63:0] writeData3_W;

    logic        byp_valid, nob_valid;
    logic [31:0] byp_instr, nob_instr;
    logic [63:0] byp_rd1, byp_rd2, byp_imm, nob_rd1, nob_rd2, nob_imm;
    logic [4:0]  byp_ra1, byp_ra2, nob_ra1, nob_ra2;

    int checks;
    int errors;
    bit check_en;

    logic [63:0] m_regs [32];
    logic        m_valid;
    logic [31:0] m_instr;
    logic [63:0] m_rd1 [2];
    logic [63:0] m_rd2 [2];
    logic [63:0] m_imm;
    logic [4:0]  m_ra1;
    logic [4:0]  m_ra2;

    decode_pipe #(.BYPASS(1)) dut_byp (
        .clk          (clk),
        .reset        (reset),
        .instr_D      (instr_D),
        .valid_D      (valid_D),
        .reg2loc_D    (reg2loc_D),
        .stall_D      (stall_D),
        .flush_D      (flush_D),
        .regWrite_W   (regWrite_W),
        .wa3_W        (wa3_W),
        .writeData3_W (writeData3_W),
        .valid_E      (byp_valid),
        .instr_E      (byp_instr),
        .readData1_E  (byp_rd1),
        .readData2_E  (byp_rd2),
        .signImm_E    (byp_imm),
        .ra1_E        (byp_ra1),
        .ra2_E        (byp_ra2)
    );

    decode_pipe #(.BYPASS(0)) dut_nob (
        .clk          (clk),
        .reset        (reset),
        .instr_D      (instr_D),
        .valid_D      (valid_D),
        .reg2loc_D    (reg2loc_D),
        .stall_D      (stall_D),
        .flush_D      (flush_D),
        .regWrite_W   (regWrite_W),
        .wa3_W        (wa3_W),
        .writeData3_W (writeData3_W),
        .valid_E      (nob_valid),
        .instr_E      (nob_instr),
        .readData1_E  (nob_rd1),
        .readData2_E  (nob_rd2),
        .signImm_E    (nob_imm),
        .ra1_E        (nob_ra1),
        .ra2_E        (nob_ra2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] add_instr(input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm);
        return {11'h458, rm, 6'd0, rn, rd};
    endfunction

    // Two's-complement value of a w-bit field, returned as a 64-bit pattern.
    function automatic logic [63:0] signed_field(input longint raw, input int w);
        longint v;
        v = raw;
        if (v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
        return 64'(v);
    endfunction

    function automatic logic [63:0] model_imm(input logic [31:0] ins);
        if (ins[31:21] == 11'h7C2 || ins[31:21] == 11'h7C0) return signed_field(longint'(ins[20:12]), 9);
        if (ins[31:24] == 8'hB4) return signed_field(longint'(ins[23:5]), 19);
        if (ins[31:26] == 6'h05) return signed_field(longint'(ins[25:0]), 26);
        return 64'd0;
    endfunction

    function automatic logic [63:0] model_read(input logic [4:0] ra, input int byp);
        if (ra == 5'd31) return 64'd0;
        if (byp != 0 && regWrite_W && wa3_W == ra) return writeData3_W;
        return m_regs[ra];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
        m_valid = 1'b0;
        m_instr = 32'd0;
        for (int b = 0; b < 2; b++) begin
            m_rd1[b] = 64'd0;
            m_rd2[b] = 64'd0;
        end
        m_imm = 64'd0;
        m_ra1 = 5'd0;
        m_ra2 = 5'd0;
    endtask

    // One clock edge of the pipeline, seen from the architectural rules.
    task automatic model_step();
        logic [4:0] ra1;
        logic [4:0] ra2;
        ra1 = instr_D[9:5];
        ra2 = reg2loc_D ? instr_D[4:0] : instr_D[20:16];
        if (flush_D) begin
            m_valid = 1'b0;
            m_instr = 32'd0;
            for (int b = 0; b < 2; b++) begin
                m_rd1[b] = 64'd0;
                m_rd2[b] = 64'd0;
            end
            m_imm = 64'd0;
            m_ra1 = 5'd0;
            m_ra2 = 5'd0;
        end else if (stall_D) begin
            for (int b = 0; b < 2; b++) begin
                if (regWrite_W && wa3_W == m_ra1 && m_ra1 != 5'd31) m_rd1[b] = writeData3_W;
                if (regWrite_W && wa3_W == m_ra2 && m_ra2 != 5'd31) m_rd2[b] = writeData3_W;
            end
        end else begin
            m_valid = valid_D;
            m_instr = instr_D;
            for (int b = 0; b < 2; b++) begin
                m_rd1[b] = model_read(ra1, 1 - b);
                m_rd2[b] = model_read(ra2, 1 - b);
            end
            m_imm = model_imm(instr_D);
            m_ra1 = ra1;
            m_ra2 = ra2;
        end
        if (regWrite_W && wa3_W != 5'd31) m_regs[wa3_W] = writeData3_W;
    endtask

    task automatic apply_stimulus(input logic [31:0] ins, input logic v, input logic r2l,
                                  input logic st, input logic fl, input logic rw,
                                  input logic [4:0] wa, input logic [63:0] wd);
        instr_D      = ins;
        valid_D      = v;
        reg2loc_D    = r2l;
        stall_D      = st;
        flush_D      = fl;
        regWrite_W   = rw;
        wa3_W        = wa;
        writeData3_W = wd;
        @(posedge clk);
        if (!reset) model_step();
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check_output({tag, " valid_E"}, 64'(byp_valid), 64'd0);
        check_output({tag, " instr_E"}, 64'(byp_instr), 64'd0);
        check_output({tag, " readData1_E"}, byp_rd1, 64'd0);
        check_output({tag, " readData2_E"}, byp_rd2, 64'd0);
        check_output({tag, " signImm_E"}, byp_imm, 64'd0);
        check_output({tag, " nobyp readData1_E"}, nob_rd1, 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #1;
        check_zero_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Every cycle out of reset, both instances must match the model.
    always @(negedge clk) begin
        if (check_en) begin
            check_output("cmp valid_E", 64'(byp_valid), 64'(m_valid));
            check_output("cmp instr_E", 64'(byp_instr), 64'(m_instr));
            check_output("cmp byp readData1_E", byp_rd1, m_rd1[0]);
            check_output("cmp byp readData2_E", byp_rd2, m_rd2[0]);
            check_output("cmp signImm_E", byp_imm, m_imm);
            check_output("cmp ra1_E", 64'(byp_ra1), 64'(m_ra1));
            check_output("cmp ra2_E", 64'(byp_ra2), 64'(m_ra2));
            check_output("cmp nobyp valid_E", 64'(nob_valid), 64'(m_valid));
            check_output("cmp nobyp instr_E", 64'(nob_instr), 64'(m_instr));
            check_output("cmp nobyp readData1_E", nob_rd1, m_rd1[1]);
            check_output("cmp nobyp readData2_E", nob_rd2, m_rd2[1]);
            check_output("cmp nobyp signImm_E", nob_imm, m_imm);
            check_output("cmp nobyp ra2_E", 64'(nob_ra2), 64'(m_ra2));
        end
    end

    initial begin
        logic [31:0] ins;
        logic [31:0] add256;
        checks       = 0;
        errors       = 0;
        check_en     = 1'b0;
        reset        = 1'b1;
        instr_D      = 32'd0;
        valid_D      = 1'b0;
        reg2loc_D    = 1'b0;
        stall_D      = 1'b0;
        flush_D      = 1'b0;
        regWrite_W   = 1'b0;
        wa3_W        = 5'd0;
        writeData3_W = 64'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("initial");
        reset    = 1'b0;
        check_en = 1'b1;

        $display("[TB] bypass test");
        apply_stimulus(add_instr(5'd1, 5'd3, 5'd4), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 64'hDEAD);
        check_output("bypass on readData1_E", byp_rd1, 64'hDEAD);
        check_output("bypass off readData1_E", nob_rd1, 64'h0);
        check_output("bypass valid_E", 64'(byp_valid), 64'd1);

        $display("[TB] XZR test");
        apply_stimulus(add_instr(5'd1, 5'd31, 5'd31), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd31, 64'h5);
        check_output("xzr readData1_E", byp_rd1, 64'h0);
        check_output("xzr readData2_E", byp_rd2, 64'h0);
        apply_stimulus(add_instr(5'd1, 5'd31, 5'd2), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0);
        check_output("xzr after write readData1_E", byp_rd1, 64'h0);

        $display("[TB] immediate test");
        apply_stimulus({11'h7C2, 9'h1FF, 2'b00, 5'd2, 5'd1}, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0);
        check_output("ldur signImm_E", byp_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        apply_stimulus({8'hB4, 19'h00010, 5'd3}, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0);
        check_output("cbz signImm_E", byp_imm, 64'h10);
        apply_stimulus({6'h05, 26'h2000000}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0);
        check_output("b signImm_E", byp_imm, 64'hFFFF_FFFF_FE00_0000);

        $display("[TB] stall refresh test");
        add256 = add_instr(5'd2, 5'd5, 5'd6);
        apply_stimulus(add256, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0);
        check_output("pre-stall readData1_E", byp_rd1, 64'h0);
        apply_stimulus(add_instr(5'd9, 5'd9, 5'd9), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 64'h77);
        check_output("refresh byp readData1_E", byp_rd1, 64'h77);
        check_output("refresh nobyp readData1_E", nob_rd1, 64'h77);
        check_output("refresh instr_E held", 64'(byp_instr), 64'(add256));

        $display("[TB] flush with stall test");
        apply_stimulus(add_instr(5'd1, 5'd2, 5'd3), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 64'h0);
        check_output("flush valid_E", 64'(byp_valid), 64'd0);
        check_output("flush instr_E", 64'(byp_instr), 64'd0);

        $display("[TB] reset test");
        apply_stimulus(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 64'd9);
        apply_stimulus(add_instr(5'd1, 5'd7, 5'd7), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0);
        check_output("X7 before reset", byp_rd1, 64'd9);
        do_reset();
        apply_stimulus(add_instr(5'd1, 5'd7, 5'd7), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0);
        check_output("X7 after reset", byp_rd1, 64'd0);
        check_output("valid after reset", 64'(byp_valid), 64'd1);

        $display("[TB] random phase");
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 4))
                0: ins = {11'h7C2, 21'($urandom)};
                1: ins = {11'h7C0, 21'($urandom)};
                2: ins = {8'hB4, 24'($urandom)};
                3: ins = {6'h05, 26'($urandom)};
                default: ins = $urandom;
            endcase
            if ($urandom_range(0, 1) == 1) begin
                ins[9:5]   = 5'($urandom_range(0, 7));
                ins[20:16] = 5'($urandom_range(0, 7));
                ins[4:0]   = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            end
            if (i == 1500) do_reset();
            apply_stimulus(ins, 1'($urandom), 1'($urandom),
                           ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
                           1'($urandom),
                           ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7)),
                           {$urandom, $urandom});
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
